// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage sequential divider: FSM state encodings,
// stall request levels, reset polarity and the default operand width.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic STOP       = 1'b1;
    localparam logic NOSTOP     = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    localparam int DIV_DATA_WIDTH = 32;

endpackage : div_sequencer_pkg

// File: rtl/div_sequencer_core_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor magnitude, and produce the next quotient bit.
module div_core_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_rem,
    input  logic [DATA_WIDTH-1:0] i_quo,
    input  logic [DATA_WIDTH-1:0] i_dmag,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic [DATA_WIDTH-1:0] o_quo
);

    // One extra bit because the shifted partial remainder can exceed DATA_WIDTH bits.
    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_diff;

    // Trial subtraction; the difference MSB is the borrow.
    always_comb begin
        w_shift = {i_rem, i_quo[DATA_WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_dmag};
        if (w_diff[DATA_WIDTH] == 1'b0) begin
            o_rem = w_diff[DATA_WIDTH-1:0];
            o_quo = {i_quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[DATA_WIDTH-1:0];
            o_quo = {i_quo[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule : div_core_step

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with stall request to the pipeline.
// Optional build macro DIV_EARLY_OUT_EN finishes at accept when |divisor| > |dividend|.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  annul,
    output logic                  ex_stall_request,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W  = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W  = {DATA_WIDTH{1'b1}};

    div_state_e r_state;
    div_state_e w_next_state;

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dmag;
    logic                  r_qneg;
    logic                  r_rneg;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;
    logic                  r_valid;
    logic                  r_dbz;

    logic                  w_nneg;
    logic                  w_dneg;
    logic [DATA_WIDTH-1:0] w_nmag;
    logic [DATA_WIDTH-1:0] w_dmag;
    logic                  w_accept;
    logic                  w_div_zero;
    logic                  w_early;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_step_rem;
    logic [DATA_WIDTH-1:0] w_step_quo;

    function automatic logic [DATA_WIDTH-1:0] f_neg_if(input logic [DATA_WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (ZERO_W - v) : v;
    endfunction

    assign w_nneg     = signed_op & dividend[DATA_WIDTH-1];
    assign w_dneg     = signed_op & divisor[DATA_WIDTH-1];
    assign w_nmag     = f_neg_if(dividend, w_nneg);
    assign w_dmag     = f_neg_if(divisor, w_dneg);
    assign w_accept   = (r_state == DIV_IDLE) && start && !annul;
    assign w_div_zero = (divisor == ZERO_W);
    assign w_last     = (r_cnt == CNT_LAST);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_dmag > w_nmag);
`else
    assign w_early = 1'b0;
`endif

    div_core_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dmag(r_dmag),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    if (w_div_zero || w_early) begin
                        w_next_state = DIV_DONE;
                    end else begin
                        w_next_state = DIV_BUSY;
                    end
                end else begin
                    w_next_state = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                if (annul) begin
                    w_next_state = DIV_IDLE;
                end else if (w_last) begin
                    w_next_state = DIV_DONE;
                end else begin
                    w_next_state = DIV_BUSY;
                end
            end
            DIV_DONE: w_next_state = DIV_IDLE;
            default:  w_next_state = DIV_IDLE;
        endcase
    end

    // FSM output: stall is combinational so the pipeline freezes in the accept cycle.
    always_comb begin
        if (start && !annul && (r_state != DIV_DONE)) begin
            ex_stall_request = STOP;
        end else begin
            ex_stall_request = NOSTOP;
        end
    end

    // Iteration datapath and result registers; results only change on entry to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_rem       <= ZERO_W;
            r_quo       <= ZERO_W;
            r_dmag      <= ZERO_W;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_cnt       <= CNT_ZERO;
            r_quotient  <= ZERO_W;
            r_remainder <= ZERO_W;
            r_valid     <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_rem  <= ZERO_W;
                        r_quo  <= w_nmag;
                        r_dmag <= w_dmag;
                        r_qneg <= w_nneg ^ w_dneg;
                        r_rneg <= w_nneg;
                        r_cnt  <= CNT_ZERO;
                        if (w_div_zero) begin
                            r_quotient  <= ONES_W;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_valid     <= 1'b1;
                        end else if (w_early) begin
                            r_quotient  <= ZERO_W;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b0;
                            r_valid     <= 1'b1;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_quotient  <= f_neg_if(w_step_quo, r_qneg);
                            r_remainder <= f_neg_if(w_step_rem, r_rneg);
                            r_dbz       <= 1'b0;
                            r_valid     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign result_valid = r_valid;
    assign quotient     = r_quotient;
    assign remainder    = r_remainder;
    assign div_by_zero  = r_dbz;

endmodule : div_sequencer
